// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, colour word layout and scan pipeline types
package vga_pkg;

    // Default 640x480@60 raster (25 MHz-class pixel rate)
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int CNT_W         = 10;
    localparam int CNT_MAX_TOTAL = 1 << CNT_W;

    // Colour word is R3 G3 B2, red in the top bits
    localparam int RGB_W_DEF = 8;
    localparam int R_W       = 3;
    localparam int G_W       = 3;
    localparam int B_W       = 2;
    localparam int R_LSB     = 5;
    localparam int G_LSB     = 2;
    localparam int B_LSB     = 0;

    typedef logic [RGB_W_DEF-1:0] color_t;
    typedef logic [CNT_W-1:0]     coord_t;

    // Raw (polarity-free) per-pixel control travelling alongside the colour request
    typedef struct packed {
        logic valid;
        logic hs;
        logic vs;
    } scan_ctl_t;

    localparam scan_ctl_t SCAN_CTL_IDLE = '{valid: 1'b0, hs: 1'b0, vs: 1'b0};

    function automatic color_t pack_rgb(input logic [R_W-1:0] r,
                                        input logic [G_W-1:0] g,
                                        input logic [B_W-1:0] b);
        return {r, g, b};
    endfunction

    // Half-open window test lo <= cnt < hi, done in int so hi may equal 1024
    function automatic logic in_window(input coord_t cnt, input int lo, input int hi);
        return (int'(cnt) >= lo) && (int'(cnt) < hi);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - clock-enabled shift register of configurable depth and width
module vga_delay_line #(
    parameter int               DEPTH   = 2,
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else if (ce_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_out.sv
// rtl/vga_scan_out.sv - raster scan, pixel request issue and latency-aligned VGA pin register
module vga_scan_out
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF,
    parameter bit SYNC_POL  = 1'b0,
    parameter int COLOR_LAT = 2,
    parameter int RGB_W     = RGB_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_ce,
    output logic [9:0]       req_x,
    output logic [9:0]       req_y,
    output logic             req_valid,
    output logic             frame_start,
    output logic             line_start,
    input  logic [RGB_W-1:0] color_in,
    output logic [RGB_W-1:0] vga_rgb,
    output logic             vga_hsync,
    output logic             vga_vsync
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int VS_START = V_ACTIVE + V_FP;

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

    if (H_TOTAL > CNT_MAX_TOTAL || V_TOTAL > CNT_MAX_TOTAL) begin : g_bad_total
        $error("vga_scan_out: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (COLOR_LAT < 1 || COLOR_LAT > 8) begin : g_bad_lat
        $error("vga_scan_out: COLOR_LAT must be in 1..8");
    end

    coord_t h_cnt_q, h_cnt_d;
    coord_t v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_ce) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Request stage and raw timing, all straight off the counters
    logic      active;
    scan_ctl_t ctl_raw;
    scan_ctl_t ctl_dly;

    assign active  = in_window(h_cnt_q, 0, H_ACTIVE) && in_window(v_cnt_q, 0, V_ACTIVE);
    assign ctl_raw = '{valid: active,
                       hs:    in_window(h_cnt_q, HS_START, HS_START + H_SYNC),
                       vs:    in_window(v_cnt_q, VS_START, VS_START + V_SYNC)};

    assign req_x     = h_cnt_q;
    assign req_y     = v_cnt_q;
    assign req_valid = active;

    // Strobes are qualified by the tick itself so a tied-high pix_ce still gives one clk
    assign line_start  = pix_ce && !rst && (h_cnt_q == '0);
    assign frame_start = pix_ce && !rst && (h_cnt_q == '0) && (v_cnt_q == '0);

    vga_delay_line #(
        .DEPTH   (COLOR_LAT),
        .WIDTH   ($bits(scan_ctl_t)),
        .RST_VAL (SCAN_CTL_IDLE)
    ) u_align (
        .clk_i (clk),
        .rst_i (rst),
        .ce_i  (pix_ce),
        .d_i   (ctl_raw),
        .q_o   (ctl_dly)
    );

    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;

    always_comb begin
        rgb_d = rgb_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        if (pix_ce) begin
            rgb_d = ctl_dly.valid ? color_in : '0;
            hs_d  = ctl_dly.hs ? SYNC_POL : ~SYNC_POL;
            vs_d  = ctl_dly.vs ? SYNC_POL : ~SYNC_POL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= '0;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end

    assign vga_rgb   = rgb_q;
    assign vga_hsync = hs_q;
    assign vga_vsync = vs_q;

endmodule
